// File: rtl/assert_result_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// assert_arb_pkg
// Shared types for the assertion result arbiter:
//   evt_t   - one result event as presented to the consumer (id, is_fail, overflow)
//   slot_t  - per-checker pending slot (valid, is_fail)
//   MAX_CHK - largest supported number of attached checkers
// -----------------------------------------------------------------------------
package assert_arb_pkg;

    localparam int MAX_CHK = 16;
    localparam int ID_W    = $clog2(MAX_CHK);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            is_fail;
        logic            overflow;
    } evt_t;

    typedef struct packed {
        logic valid;
        logic is_fail;
    } slot_t;

    // Freshly loaded slot holding one event of the given type.
    function automatic slot_t new_slot(input logic is_fail);
        slot_t s;
        s.valid   = 1'b1;
        s.is_fail = is_fail;
        return s;
    endfunction

endpackage

// File: rtl/assert_result_arbiter_if.sv
// -----------------------------------------------------------------------------
// assert_result_arbiter_if
// Valid/ready result-event channel from the arbiter to its consumer.
//   evt_valid    - event available (arbiter -> consumer)
//   evt_ready    - consumer accepts event (consumer -> arbiter)
//   evt_id       - source checker index
//   evt_is_fail  - 1 = fail event, 0 = pass event
//   evt_overflow - events from this checker were dropped before this one
// Modports: master (arbiter side), slave (consumer side).
// -----------------------------------------------------------------------------
interface assert_result_arbiter_if #(
    parameter int NUM_CHK = 4
);
    logic                       evt_valid;
    logic                       evt_ready;
    logic [$clog2(NUM_CHK)-1:0] evt_id;
    logic                       evt_is_fail;
    logic                       evt_overflow;

    modport master (
        output evt_valid,
        input  evt_ready,
        output evt_id,
        output evt_is_fail,
        output evt_overflow
    );

    modport slave (
        input  evt_valid,
        output evt_ready,
        input  evt_id,
        input  evt_is_fail,
        input  evt_overflow
    );
endinterface

// File: rtl/assert_result_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. Searches req starting at last_grant+1
// (modulo NUM_CHK) and returns the first requester found.
//   req        - request vector, one bit per checker
//   last_grant - index granted most recently
//   gnt_oh     - one-hot grant (all zero when nothing requests)
//   gnt_idx    - index of the granted requester
//   gnt_valid  - at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_CHK = 4
) (
    input  logic [NUM_CHK-1:0]         req,
    input  logic [$clog2(NUM_CHK)-1:0] last_grant,
    output logic [NUM_CHK-1:0]         gnt_oh,
    output logic [$clog2(NUM_CHK)-1:0] gnt_idx,
    output logic                       gnt_valid
);
    localparam int IDX_W = $clog2(NUM_CHK);

    // Rotating priority search: offset 1 is the checker right after last_grant.
    always_comb begin
        int              pos;
        logic [IDX_W-1:0] pos_idx;
        pos       = 0;
        pos_idx   = '0;
        gnt_oh    = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = 1; k <= NUM_CHK; k++) begin
            pos = int'(last_grant) + k;
            if (pos >= NUM_CHK) begin
                pos = pos - NUM_CHK;
            end else begin
                pos = pos;
            end
            pos_idx = IDX_W'(pos);
            if (!gnt_valid && req[pos_idx]) begin
                gnt_valid       = 1'b1;
                gnt_oh[pos_idx] = 1'b1;
                gnt_idx         = pos_idx;
            end else begin
                gnt_valid = gnt_valid;
            end
        end
    end

endmodule

// File: rtl/assert_result_arbiter.sv
// -----------------------------------------------------------------------------
// assert_result_arbiter
// Collects pass/fail pulses from NUM_CHK assertion checkers into per-checker
// one-entry pending slots, arbitrates them round-robin onto a single
// registered valid/ready event channel, and keeps saturating fail counters.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active low
//   clr        - synchronous clear of slots, overflow bits, counters, output
//   chk_en     - per-checker enable mask
//   chk_pass   - per-checker assertion pass pulse
//   chk_fail   - per-checker assertion fail pulse
//   chk_active - per-checker assertion active flag
//   cnt_sel    - fail counter select
//   fail_cnt   - selected fail counter (0 when cnt_sel >= NUM_CHK)
//   any_active - OR of enabled active flags (combinational)
//   evt        - result event channel (assert_result_arbiter_if.master)
//
// Build option: define ASSERT_ARB_FAIL_PRIO_EN to serve pending fail slots
// ahead of pass slots; otherwise one round-robin covers all slots.
// -----------------------------------------------------------------------------
module assert_result_arbiter
    import assert_arb_pkg::*;
#(
    parameter int NUM_CHK = 4,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [NUM_CHK-1:0]         chk_en,
    input  logic [NUM_CHK-1:0]         chk_pass,
    input  logic [NUM_CHK-1:0]         chk_fail,
    input  logic [NUM_CHK-1:0]         chk_active,
    input  logic [$clog2(NUM_CHK)-1:0] cnt_sel,
    output logic [CNT_W-1:0]           fail_cnt,
    output logic                       any_active,
    assert_result_arbiter_if.master    evt
);
    localparam int IDX_W = $clog2(NUM_CHK);

    slot_t            slot_r [NUM_CHK];
    logic [NUM_CHK-1:0] ovf_r;
    logic [CNT_W-1:0] cnt_r  [NUM_CHK];
    logic [IDX_W-1:0] last_grant_r;
    logic             evt_valid_r;
    evt_t             evt_r;

    logic [NUM_CHK-1:0] acc_s;
    logic [NUM_CHK-1:0] req_all_s;
    logic [NUM_CHK-1:0] req_fail_s;
    logic [NUM_CHK-1:0] gnt_a_oh_s;
    logic [IDX_W-1:0]   gnt_a_idx_s;
    logic               gnt_a_vld_s;
    logic [NUM_CHK-1:0] gnt_oh_s;
    logic [IDX_W-1:0]   gnt_idx_s;
    logic               gnt_vld_s;
    logic               load_s;
    logic [NUM_CHK-1:0] grant_s;
    logic               id_hi_unused_s;

    assign acc_s   = chk_en & (chk_pass | chk_fail);
    // Output register takes a new event when empty or being consumed.
    assign load_s  = !evt_valid_r || evt.evt_ready;
    assign grant_s = gnt_oh_s & {NUM_CHK{load_s & gnt_vld_s}};

    // Request vectors derived from the pending slots.
    always_comb begin
        req_all_s  = '0;
        req_fail_s = '0;
        for (int i = 0; i < NUM_CHK; i++) begin
            req_all_s[i]  = slot_r[i].valid;
            req_fail_s[i] = slot_r[i].valid & slot_r[i].is_fail;
        end
    end

    rr_arbiter #(.NUM_CHK(NUM_CHK)) u_rr_all (
        .req        (req_all_s),
        .last_grant (last_grant_r),
        .gnt_oh     (gnt_a_oh_s),
        .gnt_idx    (gnt_a_idx_s),
        .gnt_valid  (gnt_a_vld_s)
    );

`ifdef ASSERT_ARB_FAIL_PRIO_EN
    logic [NUM_CHK-1:0] gnt_f_oh_s;
    logic [IDX_W-1:0]   gnt_f_idx_s;
    logic               gnt_f_vld_s;

    rr_arbiter #(.NUM_CHK(NUM_CHK)) u_rr_fail (
        .req        (req_fail_s),
        .last_grant (last_grant_r),
        .gnt_oh     (gnt_f_oh_s),
        .gnt_idx    (gnt_f_idx_s),
        .gnt_valid  (gnt_f_vld_s)
    );

    // Any pending fail beats every pending pass; passes only when no fail waits.
    always_comb begin
        if (gnt_f_vld_s) begin
            gnt_oh_s  = gnt_f_oh_s;
            gnt_idx_s = gnt_f_idx_s;
            gnt_vld_s = 1'b1;
        end else begin
            gnt_oh_s  = gnt_a_oh_s;
            gnt_idx_s = gnt_a_idx_s;
            gnt_vld_s = gnt_a_vld_s;
        end
    end
`else
    logic req_fail_unused_s;
    assign req_fail_unused_s = ^req_fail_s;
    assign gnt_oh_s  = gnt_a_oh_s;
    assign gnt_idx_s = gnt_a_idx_s;
    assign gnt_vld_s = gnt_a_vld_s;
`endif

    // Pending slots and sticky overflow bits: load, overwrite/drop, clear on grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CHK; i++) begin
                slot_r[i] <= '0;
            end
            ovf_r <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_CHK; i++) begin
                slot_r[i] <= '0;
            end
            ovf_r <= '0;
        end else begin
            for (int i = 0; i < NUM_CHK; i++) begin
                if (acc_s[i]) begin
                    if (!slot_r[i].valid || grant_s[i]) begin
                        slot_r[i] <= new_slot(chk_fail[i]);
                        ovf_r[i]  <= 1'b0;
                    end else begin
                        // Full and stalled: the new event is lost, but a fail
                        // must not be hidden behind a pending pass.
                        ovf_r[i] <= 1'b1;
                        if (chk_fail[i]) begin
                            slot_r[i].is_fail <= 1'b1;
                        end
                    end
                end else if (grant_s[i]) begin
                    slot_r[i] <= '0;
                    ovf_r[i]  <= 1'b0;
                end
            end
        end
    end

    // Saturating fail counters; every accepted fail counts, even if dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CHK; i++) begin
                cnt_r[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NUM_CHK; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHK; i++) begin
                if (acc_s[i] && chk_fail[i] && (cnt_r[i] != {CNT_W{1'b1}})) begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    // Registered event output and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_valid_r  <= 1'b0;
            evt_r        <= '0;
            last_grant_r <= IDX_W'(NUM_CHK - 1);
        end else if (clr) begin
            evt_valid_r <= 1'b0;
            evt_r       <= '0;
        end else if (load_s) begin
            if (gnt_vld_s) begin
                evt_valid_r    <= 1'b1;
                evt_r.id       <= ID_W'(gnt_idx_s);
                evt_r.is_fail  <= slot_r[gnt_idx_s].is_fail;
                evt_r.overflow <= ovf_r[gnt_idx_s];
                last_grant_r   <= gnt_idx_s;
            end else begin
                evt_valid_r <= 1'b0;
            end
        end
    end

    // Selected fail counter; out-of-range selects read as zero.
    always_comb begin
        fail_cnt = '0;
        if (32'(cnt_sel) < NUM_CHK) begin
            fail_cnt = cnt_r[cnt_sel];
        end else begin
            fail_cnt = '0;
        end
    end

    assign any_active = |(chk_active & chk_en);

    assign evt.evt_valid    = evt_valid_r;
    assign evt.evt_id       = evt_r.id[IDX_W-1:0];
    assign evt.evt_is_fail  = evt_r.is_fail;
    assign evt.evt_overflow = evt_r.overflow;
    assign id_hi_unused_s   = ^evt_r.id;

endmodule

// File: tb/tb_assert_result_arbiter.sv
// -----------------------------------------------------------------------------
// tb_assert_result_arbiter
// Directed self-checking bench for assert_result_arbiter (NUM_CHK=4, CNT_W=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_assert_result_arbiter;

    logic       clk;
    logic       rst;
    logic       clr;
    logic [3:0] chk_en;
    logic [3:0] chk_pass;
    logic [3:0] chk_fail;
    logic [3:0] chk_active;
    logic [1:0] cnt_sel;
    logic [3:0] fail_cnt;
    logic       any_active;

    int checks;
    int failures;

    assert_result_arbiter_if #(.NUM_CHK(4)) evt_bus ();

    assert_result_arbiter #(.NUM_CHK(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .chk_en     (chk_en),
        .chk_pass   (chk_pass),
        .chk_fail   (chk_fail),
        .chk_active (chk_active),
        .cnt_sel    (cnt_sel),
        .fail_cnt   (fail_cnt),
        .any_active (any_active),
        .evt        (evt_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; clr = 1'b0;
        chk_en = 4'h0; chk_pass = 4'h0; chk_fail = 4'h0; chk_active = 4'h0;
        cnt_sel = 2'd0; evt_bus.evt_ready = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0;
        chk_en = 4'h0; chk_pass = 4'h0; chk_fail = 4'h0; chk_active = 4'h0;
        cnt_sel = 2'd0; evt_bus.evt_ready = 1'b0;
        #2;
        checks++; if (evt_bus.evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", evt_bus.evt_valid); end
        checks++; if (evt_bus.evt_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", evt_bus.evt_id); end
        checks++; if (evt_bus.evt_is_fail !== 1'b0) begin failures++; $display("FAIL reset_is_fail got=%b exp=0", evt_bus.evt_is_fail); end
        checks++; if (evt_bus.evt_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", evt_bus.evt_overflow); end
        checks++; if (fail_cnt !== 4'd0) begin failures++; $display("FAIL reset_fail_cnt got=%0d exp=0", fail_cnt); end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_single_pass();
        do_reset();
        chk_en = 4'hF; evt_bus.evt_ready = 1'b1; chk_pass = 4'b0100;
        tick();
        chk_pass = 4'h0;
        checks++; if (evt_bus.evt_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", evt_bus.evt_valid); end
        tick();
        checks++; if (evt_bus.evt_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", evt_bus.evt_valid); end
        checks++; if (evt_bus.evt_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2", evt_bus.evt_id); end
        checks++; if (evt_bus.evt_is_fail !== 1'b0) begin failures++; $display("FAIL single_is_fail got=%b exp=0", evt_bus.evt_is_fail); end
        checks++; if (evt_bus.evt_overflow !== 1'b0) begin failures++; $display("FAIL single_overflow got=%b exp=0", evt_bus.evt_overflow); end
        tick();
        checks++; if (evt_bus.evt_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", evt_bus.evt_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id;
        do_reset();
        chk_en = 4'hF; evt_bus.evt_ready = 1'b1; chk_pass = 4'hF;
        tick();
        chk_pass = 4'h0;
        for (int j = 0; j < 4; j++) begin
            tick();
            exp_id = 2'(j);
            checks++; if (evt_bus.evt_valid !== 1'b1) begin failures++; $display("FAIL rr_valid[%0d] got=%b exp=1", j, evt_bus.evt_valid); end
            checks++; if (evt_bus.evt_id !== exp_id) begin failures++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", j, evt_bus.evt_id, exp_id); end
        end
        tick();
        checks++; if (evt_bus.evt_valid !== 1'b0) begin failures++; $display("FAIL rr_drain got=%b exp=0", evt_bus.evt_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        chk_en = 4'hF; evt_bus.evt_ready = 1'b0;
        chk_pass = 4'b0001;
        tick();
        chk_pass = 4'b0010;
        tick();
        tick();
        chk_pass = 4'h0; chk_fail = 4'b0010;
        tick();
        chk_fail = 4'h0; cnt_sel = 2'd1;
        #1;
        checks++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_id !== 2'd0) begin failures++; $display("FAIL stall_hold got=%b/%0d exp=1/0", evt_bus.evt_valid, evt_bus.evt_id); end
        checks++; if (evt_bus.evt_is_fail !== 1'b0 || evt_bus.evt_overflow !== 1'b0) begin failures++; $display("FAIL stall_flags got=%b/%b exp=0/0", evt_bus.evt_is_fail, evt_bus.evt_overflow); end
        checks++; if (fail_cnt !== 4'd1) begin failures++; $display("FAIL ovf_fail_cnt got=%0d exp=1", fail_cnt); end
        tick();
        checks++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_id !== 2'd0) begin failures++; $display("FAIL stall_hold2 got=%b/%0d exp=1/0", evt_bus.evt_valid, evt_bus.evt_id); end
        evt_bus.evt_ready = 1'b1;
        tick();
        checks++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_id !== 2'd1) begin failures++; $display("FAIL ovf_evt got=%b/%0d exp=1/1", evt_bus.evt_valid, evt_bus.evt_id); end
        checks++; if (evt_bus.evt_is_fail !== 1'b1) begin failures++; $display("FAIL ovf_is_fail got=%b exp=1", evt_bus.evt_is_fail); end
        checks++; if (evt_bus.evt_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", evt_bus.evt_overflow); end
        tick();
        checks++; if (evt_bus.evt_valid !== 1'b0) begin failures++; $display("FAIL ovf_single got=%b exp=0", evt_bus.evt_valid); end
    endtask

    task automatic test_saturate();
        do_reset();
        chk_en = 4'hF; evt_bus.evt_ready = 1'b1; cnt_sel = 2'd3; chk_fail = 4'b1000;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 14) begin
                checks++; if (fail_cnt !== 4'd14) begin failures++; $display("FAIL sat_mid got=%0d exp=14", fail_cnt); end
            end
        end
        chk_fail = 4'h0;
        #1;
        checks++; if (fail_cnt !== 4'd15) begin failures++; $display("FAIL sat_max got=%0d exp=15", fail_cnt); end
        cnt_sel = 2'd0;
        #1;
        checks++; if (fail_cnt !== 4'd0) begin failures++; $display("FAIL sat_other got=%0d exp=0", fail_cnt); end
    endtask

    task automatic test_enable_active();
        do_reset();
        chk_en = 4'b1101; evt_bus.evt_ready = 1'b1;
        chk_pass = 4'b0010; chk_fail = 4'b0010;
        tick();
        chk_pass = 4'h0; chk_fail = 4'h0; cnt_sel = 2'd1;
        tick();
        checks++; if (evt_bus.evt_valid !== 1'b0) begin failures++; $display("FAIL en_ignore got=%b exp=0", evt_bus.evt_valid); end
        checks++; if (fail_cnt !== 4'd0) begin failures++; $display("FAIL en_cnt got=%0d exp=0", fail_cnt); end
        chk_active = 4'b0110; chk_en = 4'b0100;
        #1;
        checks++; if (any_active !== 1'b1) begin failures++; $display("FAIL active_on got=%b exp=1", any_active); end
        chk_en = 4'b1001;
        #1;
        checks++; if (any_active !== 1'b0) begin failures++; $display("FAIL active_off got=%b exp=0", any_active); end
        chk_active = 4'h0;
    endtask

    task automatic test_clear();
        do_reset();
        chk_en = 4'hF; evt_bus.evt_ready = 1'b0; chk_fail = 4'b0001;
        tick();
        chk_fail = 4'h0;
        tick();
        checks++; if (evt_bus.evt_valid !== 1'b1) begin failures++; $display("FAIL clr_pre got=%b exp=1", evt_bus.evt_valid); end
        clr = 1'b1; chk_fail = 4'b0001; evt_bus.evt_ready = 1'b1; cnt_sel = 2'd0;
        tick();
        clr = 1'b0; chk_fail = 4'h0;
        checks++; if (evt_bus.evt_valid !== 1'b0) begin failures++; $display("FAIL clr_valid got=%b exp=0", evt_bus.evt_valid); end
        checks++; if (fail_cnt !== 4'd0) begin failures++; $display("FAIL clr_cnt got=%0d exp=0", fail_cnt); end
        tick();
        checks++; if (evt_bus.evt_valid !== 1'b0) begin failures++; $display("FAIL clr_slot got=%b exp=0", evt_bus.evt_valid); end
    endtask

    task automatic test_fail_prio();
        logic [1:0] first_id;
        logic [1:0] second_id;
`ifdef ASSERT_ARB_FAIL_PRIO_EN
        first_id = 2'd2; second_id = 2'd0;
`else
        first_id = 2'd0; second_id = 2'd2;
`endif
        do_reset();
        chk_en = 4'hF; evt_bus.evt_ready = 1'b1;
        chk_pass = 4'b0001; chk_fail = 4'b0100;
        tick();
        chk_pass = 4'h0; chk_fail = 4'h0;
        tick();
        checks++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_id !== first_id) begin failures++; $display("FAIL prio_first got=%b/%0d exp=1/%0d", evt_bus.evt_valid, evt_bus.evt_id, first_id); end
        checks++; if (evt_bus.evt_is_fail !== (first_id == 2'd2)) begin failures++; $display("FAIL prio_first_type got=%b exp=%b", evt_bus.evt_is_fail, (first_id == 2'd2)); end
        tick();
        checks++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_id !== second_id) begin failures++; $display("FAIL prio_second got=%b/%0d exp=1/%0d", evt_bus.evt_valid, evt_bus.evt_id, second_id); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        chk_en = 4'hF; evt_bus.evt_ready = 1'b0; chk_fail = 4'b0010;
        tick();
        chk_fail = 4'h0;
        tick();
        checks++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_id !== 2'd1) begin failures++; $display("FAIL mid_pre got=%b/%0d exp=1/1", evt_bus.evt_valid, evt_bus.evt_id); end
        #2;
        rst = 1'b0; chk_pass = 4'hF;
        #1;
        checks++; if (evt_bus.evt_valid !== 1'b0) begin failures++; $display("FAIL mid_async got=%b exp=0", evt_bus.evt_valid); end
        checks++; if (evt_bus.evt_id !== 2'd0 || evt_bus.evt_is_fail !== 1'b0) begin failures++; $display("FAIL mid_fields got=%0d/%b exp=0/0", evt_bus.evt_id, evt_bus.evt_is_fail); end
        tick();
        chk_pass = 4'h0; rst = 1'b1;
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1;
            checks++; if (fail_cnt !== 4'd0) begin failures++; $display("FAIL mid_cnt[%0d] got=%0d exp=0", s, fail_cnt); end
        end
        evt_bus.evt_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (evt_bus.evt_valid !== 1'b0) begin failures++; $display("FAIL mid_stale[%0d] got=%b exp=0", c, evt_bus.evt_valid); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_pass();
        test_round_robin();
        test_overflow();
        test_saturate();
        test_enable_active();
        test_clear();
        test_fail_prio();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
